// File: rtl/axi_lite_vram_responder.sv
// AXI4-Lite slave for the HDMI text controller register space.
// Routes single-beat reads and writes to an external 2048x32 VRAM port
// (addr[13] = 0) or to an internal 8x32 palette register file (addr[13] = 1).
module axi_lite_vram_responder #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int VRAM_AW          = 11
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic                          bram_en,
  output logic [C_AXI_DATA_WIDTH/8-1:0] bram_we,
  output logic [VRAM_AW-1:0]            bram_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]   bram_wdata,
  input  logic [C_AXI_DATA_WIDTH-1:0]   bram_rdata,
  output logic [8*C_AXI_DATA_WIDTH-1:0] palette
);

  localparam int STRB_W    = C_AXI_DATA_WIDTH / 8;
  localparam int PAL_WORDS = 8;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic                        active_reg;
  logic                        aw_held_reg, w_held_reg;
  logic [C_AXI_ADDR_WIDTH-1:0] aw_addr_reg, ar_addr_reg;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]           wstrb_reg;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [C_AXI_DATA_WIDTH-1:0] pal_word [PAL_WORDS];

  logic aw_hs, w_hs, ar_hs;
  logic wr_commit, wr_to_pal, rd_from_pal, vram_wr_commit;
  logic unused_bits;

  // Ready flags are held low during reset and for the first cycle after it,
  // so every output reads 0 while the block is being reset.
  assign axi_awready = active_reg && (w_state_reg == W_IDLE) && !aw_held_reg;
  assign axi_wready  = active_reg && (w_state_reg == W_IDLE) && !w_held_reg;
  assign axi_arready = active_reg && (r_state_reg == R_IDLE);
  assign axi_bvalid  = (w_state_reg == W_RESP);
  assign axi_rvalid  = (r_state_reg == R_DATA);
  assign axi_bresp   = 2'b00;
  assign axi_rresp   = 2'b00;
  assign axi_rdata   = rdata_reg;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  assign wr_to_pal      = aw_addr_reg[13];
  assign rd_from_pal    = ar_addr_reg[13];
  assign wr_commit      = (w_state_reg == W_COMMIT);
  assign vram_wr_commit = wr_commit && !wr_to_pal;

  // Byte-lane offset and address bits above the decode window are don't-care.
  assign unused_bits = ^{axi_awprot, axi_arprot, aw_addr_reg[1:0], ar_addr_reg[1:0],
                         aw_addr_reg[C_AXI_ADDR_WIDTH-1:14], ar_addr_reg[C_AXI_ADDR_WIDTH-1:14]};

  // Tracks the first cycle out of reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) active_reg <= 1'b0;
    else              active_reg <= 1'b1;
  end

  // Write FSM next state: commit once both address and data are in hand.
  always_comb begin
    w_state_next = w_state_reg;
    unique case (w_state_reg)
      W_IDLE:   if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) w_state_next = W_COMMIT;
      W_COMMIT: w_state_next = W_RESP;
      W_RESP:   if (axi_bready) w_state_next = W_IDLE;
      default:  w_state_next = W_IDLE;
    endcase
  end

  // Write FSM state and independent AW / W latches.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_addr_reg <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (aw_hs) aw_addr_reg <= axi_awaddr;
      if (w_hs) begin
        wdata_reg <= axi_wdata;
        wstrb_reg <= axi_wstrb;
      end
      if (w_state_next == W_COMMIT) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
      end else begin
        if (aw_hs) aw_held_reg <= 1'b1;
        if (w_hs)  w_held_reg  <= 1'b1;
      end
    end
  end

  // Read FSM next state: a VRAM write commit owns the BRAM port, so the
  // read address phase waits a cycle and then sees the freshly written word.
  always_comb begin
    r_state_next = r_state_reg;
    unique case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_ADDR;
      R_ADDR:  if (!vram_wr_commit) r_state_next = R_WAIT;
      R_WAIT:  r_state_next = R_DATA;
      R_DATA:  if (axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM state, address latch and read-data capture/hold.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state_reg <= R_IDLE;
      ar_addr_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) ar_addr_reg <= axi_araddr;
      if (r_state_reg == R_WAIT)
        rdata_reg <= rd_from_pal ? pal_word[ar_addr_reg[4:2]] : bram_rdata;
    end
  end

  // BRAM port mux: a committing VRAM write has priority over a read.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (vram_wr_commit) begin
      bram_en    = 1'b1;
      bram_we    = wstrb_reg;
      bram_addr  = aw_addr_reg[2 +: VRAM_AW];
      bram_wdata = wdata_reg;
    end else if (r_state_reg == R_ADDR) begin
      bram_en    = 1'b1;
      bram_addr  = ar_addr_reg[2 +: VRAM_AW];
    end
  end

  // Palette register file; upper addresses alias onto the 8 words.
  for (genvar gi = 0; gi < PAL_WORDS; gi++) begin : g_pal
    logic [C_AXI_DATA_WIDTH-1:0] word_reg;

    // Byte-masked update of this palette word during the write commit.
    always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
        word_reg <= '0;
      end else if (wr_commit && wr_to_pal && (aw_addr_reg[4:2] == 3'(gi))) begin
        for (int b = 0; b < STRB_W; b++)
          if (wstrb_reg[b]) word_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
      end
    end

    assign pal_word[gi] = word_reg;
    assign palette[gi*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = word_reg;
  end

endmodule

// File: tb/tb_axi_lite_vram_responder.sv
// Self-checking bench for axi_lite_vram_responder: behavioural VRAM, shadow
// model of VRAM/palette contents, and queues of expected responses.
module tb_axi_lite_vram_responder;

  logic         clk = 1'b0;
  logic         axi_aresetn;
  logic [15:0]  axi_awaddr, axi_araddr;
  logic [2:0]   axi_awprot, axi_arprot;
  logic         axi_awvalid, axi_awready;
  logic [31:0]  axi_wdata;
  logic [3:0]   axi_wstrb;
  logic         axi_wvalid, axi_wready;
  logic [1:0]   axi_bresp, axi_rresp;
  logic         axi_bvalid, axi_bready;
  logic         axi_arvalid, axi_arready;
  logic [31:0]  axi_rdata;
  logic         axi_rvalid, axi_rready;
  logic         bram_en;
  logic [3:0]   bram_we;
  logic [10:0]  bram_addr;
  logic [31:0]  bram_wdata, bram_rdata;
  logic [255:0] palette;

  int checks = 0;
  int failures = 0;

  logic [31:0] bram_mem [2048];
  logic [31:0] exp_vram [2048];
  logic [31:0] exp_pal  [8];
  logic [31:0] rd_q [$];
  logic [1:0]  b_q  [$];

  always #5 clk = ~clk;

  axi_lite_vram_responder #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16), .VRAM_AW(11)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .palette(palette)
  );

  // Single-port VRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bram_mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
      if (bram_we == 4'b0000) bram_rdata <= bram_mem[bram_addr];
    end
  end

  function automatic void apply_model(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (a[13]) exp_pal[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
        else       exp_vram[a[12:2]][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a[13]) return exp_pal[a[4:2]];
    return exp_vram[a[12:2]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with simultaneous AW+W; checks commit cycle, BVALID latency,
  // hold under bready=0, response code and single-cycle completion.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit quiet);
    int cnt, edges;
    bit aw_done, w_done, aw_s, w_s;
    logic [1:0] exp_b;
    axi_awaddr = addr; axi_awvalid = 1'b1;
    axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1; axi_bready = 1'b0;
    cnt = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cnt < 50) begin
      aw_s = axi_awready && axi_awvalid;
      w_s  = axi_wready && axi_wvalid;
      tick();
      if (aw_s) begin aw_done = 1; axi_awvalid = 1'b0; end
      if (w_s)  begin w_done = 1;  axi_wvalid = 1'b0;  end
      cnt++;
    end
    checks++;
    if (!(aw_done && w_done)) begin
      failures++;
      $display("FAIL wr_handshake addr=%h got aw=%0d w=%0d want 1 1", addr, aw_done, w_done);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      return;
    end
    apply_model(addr, data, strb);
    b_q.push_back(2'b00);
    if (!addr[13]) begin
      checks++;
      if ({bram_en, bram_we, bram_addr, bram_wdata} !== {1'b1, strb, addr[12:2], data}) begin
        failures++;
        $display("FAIL wr_commit_bram got en=%b we=%h a=%0d d=%h want 1 %h %0d %h",
                 bram_en, bram_we, bram_addr, bram_wdata, strb, addr[12:2], data);
      end
    end
    edges = 1;
    while (!axi_bvalid && edges < 20) begin tick(); edges++; end
    checks++;
    if (edges !== 2) begin
      failures++;
      $display("FAIL wr_bvalid_latency got %0d want 2", edges);
    end
    tick();
    checks++;
    if (axi_bvalid !== 1'b1) begin
      failures++;
      $display("FAIL wr_bvalid_hold got %b want 1", axi_bvalid);
    end
    axi_bready = 1'b1;
    exp_b = b_q.pop_front();
    checks++;
    if (axi_bresp !== exp_b) begin
      failures++;
      $display("FAIL wr_bresp got %b want %b", axi_bresp, exp_b);
    end
    tick();
    axi_bready = 1'b0;
    checks++;
    if (axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_bvalid_clear got %b want 0", axi_bvalid);
    end
    if (addr[13]) begin
      checks++;
      if (palette[addr[4:2]*32 +: 32] !== exp_pal[addr[4:2]]) begin
        failures++;
        $display("FAIL wr_palette idx=%0d got %h want %h", addr[4:2], palette[addr[4:2]*32 +: 32], exp_pal[addr[4:2]]);
      end
    end
    if (!quiet) $display("WR addr=%h data=%h strb=%h blat=%0d", addr, data, strb, edges);
  endtask

  // Read with optional rready backpressure; checks latency, data and hold.
  task automatic axi_read(input logic [15:0] addr, input int hold, input bit quiet);
    int cnt, edges;
    bit done, ar_s;
    logic [31:0] got, expv;
    rd_q.push_back(model_read(addr));
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = (hold == 0);
    cnt = 0; done = 0;
    while (!done && cnt < 50) begin
      ar_s = axi_arready && axi_arvalid;
      tick();
      if (ar_s) begin done = 1; axi_arvalid = 1'b0; end
      cnt++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rd_handshake addr=%h got no arready want arready", addr);
      axi_arvalid = 1'b0;
      void'(rd_q.pop_front());
      return;
    end
    edges = 1;
    while (!axi_rvalid && edges < 20) begin tick(); edges++; end
    checks++;
    if (edges !== 3) begin
      failures++;
      $display("FAIL rd_rvalid_latency addr=%h got %0d want 3", addr, edges);
    end
    got = axi_rdata;
    expv = rd_q.pop_front();
    checks++;
    if (got !== expv || axi_rresp !== 2'b00) begin
      failures++;
      $display("FAIL rd_data addr=%h got %h/%b want %h/00", addr, got, axi_rresp, expv);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (axi_rvalid !== 1'b1 || axi_rdata !== got || axi_arready !== 1'b0) begin
        failures++;
        $display("FAIL rd_hold cyc=%0d got rv=%b d=%h arr=%b want 1 %h 0", i, axi_rvalid, axi_rdata, axi_arready, got);
      end
    end
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    checks++;
    if (axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_rvalid_clear got %b want 0", axi_rvalid);
    end
    if (!quiet) $display("RD addr=%h data=%h lat=%0d", addr, got, edges);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata,
         bram_en, bram_we, bram_addr, bram_wdata, palette} !== '0) begin
      failures++;
      $display("FAIL %s_outputs got awr=%b wr=%b bv=%b arr=%b rv=%b rd=%h en=%b pal0=%h want all 0",
               tag, axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata, bram_en, palette[31:0]);
    end
  endtask

  task automatic test_reset();
    axi_aresetn = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    axi_aresetn = 1'b1;
    tick(); tick();
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release_ready got %b want 111", {axi_awready, axi_wready, axi_arready});
    end
    $display("RESET done");
  endtask

  task automatic test_simul_write();
    axi_write(16'h0004, 32'h69207420, 4'hF, 1'b0);
  endtask

  task automatic test_w_before_aw();
    int cnt;
    bit done, w_s;
    axi_wdata = 32'h0FFF0000; axi_wstrb = 4'hF; axi_wvalid = 1'b1; axi_bready = 1'b0;
    cnt = 0; done = 0;
    while (!done && cnt < 50) begin
      w_s = axi_wready && axi_wvalid;
      tick();
      if (w_s) begin done = 1; axi_wvalid = 1'b0; end
      cnt++;
    end
    checks++;
    if (!done || axi_wready !== 1'b0) begin
      failures++;
      $display("FAIL wfirst_wready_drop got hs=%0d wready=%b want 1 0", done, axi_wready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (axi_bvalid !== 1'b0 || bram_en !== 1'b0 || palette[31:0] !== exp_pal[0]) begin
        failures++;
        $display("FAIL wfirst_no_commit cyc=%0d got bv=%b en=%b p0=%h want 0 0 %h", i, axi_bvalid, bram_en, palette[31:0], exp_pal[0]);
      end
    end
    axi_awaddr = 16'h2002; axi_awvalid = 1'b1;
    cnt = 0; done = 0;
    while (!done && cnt < 50) begin
      w_s = axi_awready && axi_awvalid;
      tick();
      if (w_s) begin done = 1; axi_awvalid = 1'b0; end
      cnt++;
    end
    apply_model(16'h2002, 32'h0FFF0000, 4'hF);
    cnt = 0;
    while (!axi_bvalid && cnt < 20) begin tick(); cnt++; end
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    checks++;
    if (palette[31:0] !== exp_pal[0] || axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL wfirst_palette got %h bv=%b want %h 0", palette[31:0], axi_bvalid, exp_pal[0]);
    end
    $display("WR(W first) addr=2002 data=0fff0000 pal0=%h", palette[31:0]);
  endtask

  task automatic test_byte_strobe();
    axi_write(16'h2004, 32'h11223344, 4'hF, 1'b0);
    axi_write(16'h2004, 32'hAABBCCDD, 4'b0101, 1'b0);
    checks++;
    if (exp_pal[1] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_model got %h want 11bb33dd", exp_pal[1]);
    end
    axi_read(16'h2004, 0, 1'b0);
    axi_read(16'h3FE4, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    axi_write(16'h0008, 32'h74206E20, 4'hF, 1'b0);
    axi_read(16'h0008, 10, 1'b0);
  endtask

  task automatic test_readback();
    for (int i = 0; i < 600; i++) axi_write(16'(i * 4), 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 600; i++) axi_read(16'(i * 4), 0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    int cnt;
    bit done, aw_s;
    axi_awaddr = 16'h0010; axi_awvalid = 1'b1;
    cnt = 0; done = 0;
    while (!done && cnt < 50) begin
      aw_s = axi_awready && axi_awvalid;
      tick();
      if (aw_s) begin done = 1; axi_awvalid = 1'b0; end
      cnt++;
    end
    axi_aresetn = 1'b0;
    tick();
    check_all_zero("midwr_reset");
    for (int i = 0; i < 8; i++) exp_pal[i] = '0;
    axi_aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (axi_bvalid !== 1'b0) begin
        failures++;
        $display("FAIL midwr_no_stale_bvalid got %b want 0", axi_bvalid);
      end
    end
    axi_write(16'h0014, 32'hCAFE0014, 4'hF, 1'b0);
    axi_read(16'h0014, 0, 1'b0);
  endtask

  initial begin
    axi_aresetn = 1'b0;
    axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;
    axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    for (int i = 0; i < 8; i++) exp_pal[i] = '0;
    for (int i = 0; i < 2048; i++) exp_vram[i] = '0;
    tick();
    test_reset();
    test_simul_write();
    test_w_before_aw();
    test_byte_strobe();
    test_backpressure();
    test_readback();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
